axon_spike_scheduler: RTL and testbench
=======================================

Name: axon_spike_scheduler

Overview:
- Consumes local-delivery spike events from the core router (dx=dy=0 packets already decoded to axon id + delivery tick) and buffers them per tick in a 16-slot circular axon scheduler.
- On each 1 kHz tick, advances the current-tick pointer and presents that slot's 256-bit axon-activity vector to the neuron block, then clears the slot.
- Sits between the router local-eject port and the neuron/synapse evaluation stage inside truenorth_core.

Parameters:
- NUM_AXONS, 256, axons per core; width of slot vector and axon_vec.
- AXON_W, 8, axon id width (log2 NUM_AXONS).
- NUM_SLOTS, 16, scheduler depth; must equal 2^TICK_W.
- TICK_W, 4, delivery-tick field width.
- CNT_W, 16, drop/overrun counter width.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle 1 kHz synchronisation pulse.
- spk_axon  in  AXON_W  target axon id.
- spk_dtick  in  TICK_W  delivery offset in ticks, relative to the current tick.
- spk_valid  in  1  spike event valid.
- spk_ready  out  1  scheduler can accept an event this cycle.
- axon_vec  out  NUM_AXONS  active axons for the current tick.
- axon_valid  out  1  axon_vec valid; held until accepted.
- axon_ready  in  1  neuron block accepts axon_vec.
- cur_tick  out  TICK_W  current slot pointer.
- drop_cnt  out  CNT_W  count of illegal (dtick=0) events dropped; saturates.
- overrun  out  1  sticky; set when a tick arrives while not in IDLE.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, rst_n=0): all slots cleared, cur_tick=0, state=IDLE, spk_ready=0 for the reset cycle then 1, axon_valid=0, axon_vec=0, drop_cnt=0, overrun=0, busy=0.
- Storage: NUM_SLOTS x NUM_AXONS flop array. Slot index is (cur_tick + spk_dtick) mod NUM_SLOTS; wraps naturally in TICK_W bits.
- Accept: a handshake occurs when spk_valid & spk_ready. The bit [spk_axon] of the target slot is ORed with 1 on the next edge. Duplicate events are idempotent.
- spk_dtick=0 is illegal: the event is accepted (handshake completes), not written, and drop_cnt increments, saturating at all-ones.
- spk_ready=1 only in IDLE.
- FSM:
  - IDLE: on tick -> ADVANCE. A spike handshaking in the same cycle as tick uses the old cur_tick.
  - ADVANCE (1 cycle): cur_tick <= cur_tick+1 (wraps 15->0) -> PRESENT.
  - PRESENT: axon_vec = slot[cur_tick], axon_valid=1. Hold axon_vec stable until axon_ready. On handshake -> CLEAR.
  - CLEAR (1 cycle): slot[cur_tick] <= 0; axon_valid=0 -> IDLE.
- Latency: tick to axon_valid is 2 cycles (tick edge -> ADVANCE, then PRESENT). An empty slot is still presented as all-zero, with axon_valid=1.
- Tick while not IDLE: overrun is set (sticky until reset); one pending tick is latched. On return to IDLE the pending tick is consumed, forcing IDLE->ADVANCE. Further ticks while a tick is already pending are lost; overrun stays set.
- An event with dtick=d accepted while cur_tick=c appears on axon_vec at the d-th subsequent tick.
- Reset mid-PRESENT: outputs drop immediately to their reset values; all buffered spikes are lost.

Test Plan:
- Reset, then spike axon=10, dtick=1 at cur_tick=0; pulse tick -> after 2 cycles axon_valid=1, cur_tick=1, axon_vec has only bit 10 set. After axon_ready, next tick presents all-zero.
- Spikes axon=5 dtick=3, axon=200 dtick=3, axon=5 dtick=3 (duplicate) -> at third tick, axon_vec bits 5 and 200 set, popcount 2; slots for ticks 1 and 2 are all-zero.
- Wrap: advance to cur_tick=14, spike axon=7 dtick=4 -> presented when cur_tick=2 (after 4 ticks), not before.
- spk_dtick=0 x3 -> drop_cnt=3, no axon_vec bits set on the next 16 ticks.
- Hold axon_ready=0 through a second tick -> overrun=1. After axon_ready=1, the pending tick is presented immediately (cur_tick advances by 2 in total); spk_ready stays 0 throughout.
- Same-cycle tick and spike dtick=1 at cur_tick=3 -> bit presented at cur_tick=4 (the immediate tick). Assert rst_n low mid-PRESENT -> axon_valid=0 and cur_tick=0 asynchronously.

Source files
------------

// File: rtl/axon_spike_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : axon_spike_scheduler
//  Purpose  : Circular per-tick axon scheduler. Local spike events are
//             buffered in slot (cur_tick + dtick). On each tick the next
//             slot is presented to the neuron block and then cleared.
//  Revision : 1.0 - initial release
// ============================================================================
module axon_spike_scheduler #(
   parameter int NUM_AXONS = 256,
   parameter int AXON_W    = 8,
   parameter int NUM_SLOTS = 16,
   parameter int TICK_W    = 4,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tick,
   input  logic [AXON_W-1:0]    spk_axon,
   input  logic [TICK_W-1:0]    spk_dtick,
   input  logic                 spk_valid,
   output logic                 spk_ready,
   output logic [NUM_AXONS-1:0] axon_vec,
   output logic                 axon_valid,
   input  logic                 axon_ready,
   output logic [TICK_W-1:0]    cur_tick,
   output logic [CNT_W-1:0]     drop_cnt,
   output logic                 overrun,
   output logic                 busy
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ADVANCE = 2'd1,
      S_PRESENT = 2'd2,
      S_CLEAR   = 2'd3
   } state_t;

   state_t                               state_q, state_d;
   logic [TICK_W-1:0]                    cur_tick_q, cur_tick_d;
   logic                                 pend_q, pend_d;
   logic                                 overrun_q, overrun_d;
   logic [CNT_W-1:0]                     drop_cnt_q, drop_cnt_d;
   logic                                 ready_en_q;
   logic [NUM_SLOTS-1:0][NUM_AXONS-1:0]  slots_q;

   logic                                 w_idle;
   logic                                 w_hs;
   logic                                 w_legal;
   logic [TICK_W-1:0]                    w_slot_idx;

   // Handshake and target-slot decode; slot index wraps in TICK_W bits.
   // A pending tick blocks acceptance so the forced advance is not delayed.
   assign w_idle     = (state_q == S_IDLE);
   assign spk_ready  = ready_en_q & w_idle & ~pend_q;
   assign w_hs       = spk_valid & spk_ready;
   assign w_legal    = (spk_dtick != '0);
   assign w_slot_idx = cur_tick_q + spk_dtick;

   // Holds spk_ready low for the first cycle after reset is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en_q <= 1'b0;
      end else begin
         ready_en_q <= 1'b1;
      end
   end

   // Control state, tick pointer, pending tick, overrun flag, drop counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cur_tick_q <= '0;
         pend_q     <= 1'b0;
         overrun_q  <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cur_tick_q <= cur_tick_d;
         pend_q     <= pend_d;
         overrun_q  <= overrun_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Next-state logic: IDLE -> ADVANCE -> PRESENT -> CLEAR -> IDLE.
   always_comb begin
      state_d    = state_q;
      cur_tick_d = cur_tick_q;
      pend_d     = pend_q;
      overrun_d  = overrun_q;
      drop_cnt_d = drop_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (tick || pend_q) begin
               state_d = S_ADVANCE;
               // A fresh tick arriving while a pending one is consumed stays queued.
               pend_d  = pend_q & tick;
            end
         end
         S_ADVANCE: begin
            cur_tick_d = cur_tick_q + TICK_W'(1);
            state_d    = S_PRESENT;
         end
         S_PRESENT: begin
            if (axon_ready) begin
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Ticks outside IDLE: latch at most one, flag the overrun.
      if (tick && !w_idle) begin
         pend_d    = 1'b1;
         overrun_d = 1'b1;
      end

      // dtick=0 events are consumed but only counted, saturating.
      if (w_hs && !w_legal && (drop_cnt_q != {CNT_W{1'b1}})) begin
         drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
   end

   // Slot storage: set the addressed axon bit on accept, wipe slot on CLEAR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slots_q <= '0;
      end else if (state_q == S_CLEAR) begin
         slots_q[cur_tick_q] <= '0;
      end else if (w_hs && w_legal) begin
         slots_q[w_slot_idx][spk_axon] <= 1'b1;
      end
   end

   // Outputs; the presented slot cannot change while PRESENT since no
   // events are accepted outside IDLE.
   assign axon_valid = (state_q == S_PRESENT);
   assign axon_vec   = (state_q == S_PRESENT) ? slots_q[cur_tick_q] : '0;
   assign cur_tick   = cur_tick_q;
   assign drop_cnt   = drop_cnt_q;
   assign overrun    = overrun_q;
   assign busy       = ~w_idle;

endmodule
`default_nettype wire

// File: tb/tb_axon_spike_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axon_spike_scheduler
//  Purpose  : Directed self-checking bench for axon_spike_scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axon_spike_scheduler;

   logic         clk;
   logic         rst_n;
   logic         tick;
   logic [7:0]   spk_axon;
   logic [3:0]   spk_dtick;
   logic         spk_valid;
   logic         spk_ready;
   logic [255:0] axon_vec;
   logic         axon_valid;
   logic         axon_ready;
   logic [3:0]   cur_tick;
   logic [15:0]  drop_cnt;
   logic         overrun;
   logic         busy;

   int n_checks = 0;
   int n_fail   = 0;

   axon_spike_scheduler #(
      .NUM_AXONS (256),
      .AXON_W    (8),
      .NUM_SLOTS (16),
      .TICK_W    (4),
      .CNT_W     (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .spk_axon   (spk_axon),
      .spk_dtick  (spk_dtick),
      .spk_valid  (spk_valid),
      .spk_ready  (spk_ready),
      .axon_vec   (axon_vec),
      .axon_valid (axon_valid),
      .axon_ready (axon_ready),
      .cur_tick   (cur_tick),
      .drop_cnt   (drop_cnt),
      .overrun    (overrun),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Sends one event starting from a negedge in IDLE.
   task automatic send_spike(input logic [7:0] ax, input logic [3:0] dt);
      @(negedge clk);
      spk_axon  = ax;
      spk_dtick = dt;
      spk_valid = 1'b1;
      @(negedge clk);
      spk_valid = 1'b0;
   endtask

   // Pulses tick, waits (bounded) for the presentation, captures it,
   // accepts it and returns once the scheduler is back in IDLE.
   task automatic advance(output logic [255:0] vec, output logic [3:0] ct,
                          output int lat);
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      lat  = 1;
      while (!axon_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      vec = axon_vec;
      ct  = cur_tick;
      axon_ready = 1'b1;
      @(negedge clk);
      axon_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (spk_ready !== 1'b0) begin n_fail++; $display("FAIL reset_spk_ready got=%b exp=0", spk_ready); end
      n_checks++; if (axon_valid !== 1'b0) begin n_fail++; $display("FAIL reset_axon_valid got=%b exp=0", axon_valid); end
      n_checks++; if (axon_vec !== 256'd0) begin n_fail++; $display("FAIL reset_axon_vec got=%h exp=0", axon_vec); end
      n_checks++; if (cur_tick !== 4'd0) begin n_fail++; $display("FAIL reset_cur_tick got=%0d exp=0", cur_tick); end
      n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (spk_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_spk_ready got=%b exp=1", spk_ready); end
   endtask

   task automatic test_single_spike;
      logic [255:0] v;
      logic [255:0] exp_v;
      logic [3:0]   ct;
      int           lat;
      exp_v     = '0;
      exp_v[10] = 1'b1;
      send_spike(8'd10, 4'd1);
      advance(v, ct, lat);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL single_latency got=%0d exp=2", lat); end
      n_checks++; if (ct !== 4'd1) begin n_fail++; $display("FAIL single_cur_tick got=%0d exp=1", ct); end
      n_checks++; if (v !== exp_v) begin n_fail++; $display("FAIL single_vec got=%h exp=%h", v, exp_v); end
      advance(v, ct, lat);
      n_checks++; if (ct !== 4'd2) begin n_fail++; $display("FAIL single_next_tick got=%0d exp=2", ct); end
      n_checks++; if (v !== 256'd0) begin n_fail++; $display("FAIL single_next_vec got=%h exp=0", v); end
   endtask

   task automatic test_multi_dup;
      logic [255:0] v;
      logic [255:0] exp_v;
      logic [3:0]   ct;
      int           lat;
      exp_v      = '0;
      exp_v[5]   = 1'b1;
      exp_v[200] = 1'b1;
      // cur_tick is 2 here; all three target slot 5
      send_spike(8'd5,   4'd3);
      send_spike(8'd200, 4'd3);
      send_spike(8'd5,   4'd3);
      advance(v, ct, lat);
      n_checks++; if (v !== 256'd0) begin n_fail++; $display("FAIL multi_t1_vec got=%h exp=0", v); end
      advance(v, ct, lat);
      n_checks++; if (v !== 256'd0) begin n_fail++; $display("FAIL multi_t2_vec got=%h exp=0", v); end
      advance(v, ct, lat);
      n_checks++; if (ct !== 4'd5) begin n_fail++; $display("FAIL multi_cur_tick got=%0d exp=5", ct); end
      n_checks++; if (v !== exp_v) begin n_fail++; $display("FAIL multi_vec got=%h exp=%h", v, exp_v); end
      n_checks++; if ($countones(v) !== 2) begin n_fail++; $display("FAIL multi_popcount got=%0d exp=2", $countones(v)); end
   endtask

   task automatic test_wrap;
      logic [255:0] v;
      logic [255:0] exp_v;
      logic [3:0]   ct;
      int           lat;
      int           early;
      exp_v    = '0;
      exp_v[7] = 1'b1;
      for (int i = 0; i < 9; i++) advance(v, ct, lat);   // 5 -> 14
      n_checks++; if (cur_tick !== 4'd14) begin n_fail++; $display("FAIL wrap_start_tick got=%0d exp=14", cur_tick); end
      send_spike(8'd7, 4'd4);
      early = 0;
      for (int i = 0; i < 3; i++) begin
         advance(v, ct, lat);
         if (v !== 256'd0) early++;
      end
      n_checks++; if (early !== 0) begin n_fail++; $display("FAIL wrap_early_nonzero got=%0d exp=0", early); end
      advance(v, ct, lat);
      n_checks++; if (ct !== 4'd2) begin n_fail++; $display("FAIL wrap_cur_tick got=%0d exp=2", ct); end
      n_checks++; if (v !== exp_v) begin n_fail++; $display("FAIL wrap_vec got=%h exp=%h", v, exp_v); end
   endtask

   task automatic test_drop;
      logic [255:0] v;
      logic [3:0]   ct;
      int           lat;
      int           nonzero;
      send_spike(8'd1,  4'd0);
      send_spike(8'd99, 4'd0);
      send_spike(8'd1,  4'd0);
      n_checks++; if (drop_cnt !== 16'd3) begin n_fail++; $display("FAIL drop_cnt got=%0d exp=3", drop_cnt); end
      nonzero = 0;
      for (int i = 0; i < 16; i++) begin
         advance(v, ct, lat);
         if (v !== 256'd0) nonzero++;
      end
      n_checks++; if (nonzero !== 0) begin n_fail++; $display("FAIL drop_vec_nonzero got=%0d exp=0", nonzero); end
      n_checks++; if (cur_tick !== 4'd2) begin n_fail++; $display("FAIL drop_end_tick got=%0d exp=2", cur_tick); end
   endtask

   task automatic test_overrun;
      int rdy_hi;
      int k;
      rdy_hi = 0;
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_initial got=%b exp=0", overrun); end
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0; if (spk_ready) rdy_hi++;
      @(negedge clk); if (spk_ready) rdy_hi++;
      n_checks++; if (axon_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_present got=%b exp=1", axon_valid); end
      n_checks++; if (cur_tick !== 4'd3) begin n_fail++; $display("FAIL ovr_tick_first got=%0d exp=3", cur_tick); end
      // second tick while PRESENT is held
      tick = 1'b1;
      @(negedge clk); tick = 1'b0; if (spk_ready) rdy_hi++;
      n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
      n_checks++; if (axon_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_held got=%b exp=1", axon_valid); end
      // third tick is lost
      tick = 1'b1;
      @(negedge clk); tick = 1'b0; if (spk_ready) rdy_hi++;
      axon_ready = 1'b1;
      @(negedge clk); axon_ready = 1'b0;
      k = 0;
      while (!axon_valid && k < 20) begin
         if (spk_ready) rdy_hi++;
         @(negedge clk);
         k++;
      end
      n_checks++; if (k !== 3) begin n_fail++; $display("FAIL ovr_pending_delay got=%0d exp=3", k); end
      n_checks++; if (cur_tick !== 4'd4) begin n_fail++; $display("FAIL ovr_tick_total got=%0d exp=4", cur_tick); end
      n_checks++; if (rdy_hi !== 0) begin n_fail++; $display("FAIL ovr_spk_ready_high got=%0d exp=0", rdy_hi); end
      axon_ready = 1'b1;
      @(negedge clk); axon_ready = 1'b0;
      repeat (4) @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovr_lost_tick_busy got=%b exp=0", busy); end
      n_checks++; if (cur_tick !== 4'd4) begin n_fail++; $display("FAIL ovr_lost_tick_ct got=%0d exp=4", cur_tick); end
      n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
   endtask

   task automatic test_same_cycle_and_reset;
      logic [255:0] v;
      logic [255:0] exp_v;
      logic [3:0]   ct;
      int           lat;
      int           k;
      exp_v     = '0;
      exp_v[33] = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) advance(v, ct, lat);     // 0 -> 3
      @(negedge clk);
      tick      = 1'b1;
      spk_valid = 1'b1;
      spk_axon  = 8'd33;
      spk_dtick = 4'd1;
      @(negedge clk);
      tick      = 1'b0;
      spk_valid = 1'b0;
      k = 1;
      while (!axon_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      n_checks++; if (cur_tick !== 4'd4) begin n_fail++; $display("FAIL same_cur_tick got=%0d exp=4", cur_tick); end
      n_checks++; if (axon_vec !== exp_v) begin n_fail++; $display("FAIL same_vec got=%h exp=%h", axon_vec, exp_v); end
      // asynchronous reset while PRESENT
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (axon_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got=%b exp=0", axon_valid); end
      n_checks++; if (cur_tick !== 4'd0) begin n_fail++; $display("FAIL rst_mid_cur_tick got=%0d exp=0", cur_tick); end
      n_checks++; if (axon_vec !== 256'd0) begin n_fail++; $display("FAIL rst_mid_vec got=%h exp=0", axon_vec); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) advance(v, ct, lat);     // 0 -> 4
      n_checks++; if (ct !== 4'd4) begin n_fail++; $display("FAIL rst_lost_tick got=%0d exp=4", ct); end
      n_checks++; if (v !== 256'd0) begin n_fail++; $display("FAIL rst_lost_vec got=%h exp=0", v); end
   endtask

   initial begin
      rst_n      = 1'b0;
      tick       = 1'b0;
      spk_axon   = '0;
      spk_dtick  = '0;
      spk_valid  = 1'b0;
      axon_ready = 1'b0;
      test_reset();
      test_single_spike();
      test_multi_dup();
      test_wrap();
      test_drop();
      test_overrun();
      test_same_cycle_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
